// File: rtl/nios_7seg_ctrl.sv
// ============================================================================
// Module   : nios_7seg_ctrl
// Brief    : Avalon-MM slave driving DIGITS seven-segment displays (hex decode,
//            blank, blink, leading-zero suppression).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_7seg_ctrl #(
  parameter int          DIGITS      = 6,
  parameter logic [31:0] BLINK_RESET = 32'd25000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [7*DIGITS-1:0]   out_port
);

  localparam int c_DATA_W = 4 * DIGITS;
  localparam int c_OUT_W  = 7 * DIGITS;

  logic [c_DATA_W-1:0] r_data;
  logic [DIGITS-1:0]   r_blank;
  logic [DIGITS-1:0]   r_blink;
  logic                r_lzs;
  logic [31:0]         r_blink_half;
  logic [31:0]         r_cnt;
  logic                r_phase;
  logic [c_OUT_W-1:0]  r_out;

  logic                w_wr;
  logic [31:0]         w_data32;
  logic [7:0]          w_blank8;
  logic [7:0]          w_blink8;
  logic [c_OUT_W-1:0]  w_seg_next;
  logic                w_all_zero;
  logic                w_off;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  assign w_wr = chipselect && !write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data       <= '0;
      r_blank      <= '0;
      r_blink      <= '0;
      r_lzs        <= 1'b0;
      r_blink_half <= BLINK_RESET;
    end else if (w_wr) begin
      case (address)
        2'd0: r_data <= writedata[c_DATA_W-1:0];
        2'd1: begin
          r_blank <= writedata[DIGITS-1:0];
          r_blink <= writedata[8 +: DIGITS];
          r_lzs   <= writedata[16];
        end
        2'd2: r_blink_half <= writedata;
        default: ;
      endcase
    end
  end

  // A write to BLINK_HALF restarts the timebase and wins over a coincident toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if ((w_wr && address == 2'd2) || r_blink_half == 32'd0) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == r_blink_half - 32'd1) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Scan from the top digit down so w_all_zero covers nibbles i..DIGITS-1.
  always_comb begin
    w_seg_next = '0;
    w_all_zero = 1'b1;
    w_off      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_all_zero = w_all_zero && (r_data[4*i +: 4] == 4'h0);
      w_off = r_blank[i] || (r_blink[i] && r_phase) || (r_lzs && (i > 0) && w_all_zero);
      w_seg_next[7*i +: 7] = w_off ? 7'h7F : hex_decode(r_data[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= {DIGITS{7'h40}};
    end else begin
      r_out <= w_seg_next;
    end
  end

  assign out_port = r_out;

  always_comb begin
    w_data32                  = '0;
    w_data32[c_DATA_W-1:0]    = r_data;
    w_blank8                  = '0;
    w_blank8[DIGITS-1:0]      = r_blank;
    w_blink8                  = '0;
    w_blink8[DIGITS-1:0]      = r_blink;
    readdata                  = '0;
    case (address)
      2'd0:    readdata = w_data32;
      2'd1:    readdata = {15'd0, r_lzs, w_blink8, w_blank8};
      2'd2:    readdata = r_blink_half;
      default: readdata = {31'd0, r_phase};
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_nios_7seg_ctrl.sv
// ============================================================================
// Module   : tb_nios_7seg_ctrl
// Brief    : Self-checking bench for nios_7seg_ctrl with a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nios_7seg_ctrl;

  localparam int D = 6;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [41:0] ALL_ZERO_OUT = {6{7'h40}};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [41:0] out_port;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nios_7seg_ctrl #(.DIGITS(D), .BLINK_RESET(32'd25000000)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  // Reference model: register file plus elapsed-cycle count since the timebase was cleared.
  logic [23:0] m_data;
  logic [5:0]  m_blank, m_blink;
  logic        m_lzs;
  logic [31:0] m_half;
  longint      m_ticks;
  logic [41:0] m_out;

  function automatic logic m_phase();
    if (m_half == 32'd0) return 1'b0;
    return ((m_ticks / longint'(m_half)) % 2) == 1;
  endfunction

  function automatic logic [41:0] expect_out(input logic [23:0] d, input logic [5:0] bl,
                                             input logic [5:0] bk, input logic lz, input logic ph);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      logic allz;
      logic off;
      allz = 1'b1;
      for (int j = i; j < D; j++) if (d[4*j +: 4] != 4'h0) allz = 1'b0;
      off = bl[i] || (bk[i] && ph) || (lz && i > 0 && allz);
      r[7*i +: 7] = off ? 7'h7F : SEG[d[4*i +: 4]];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {8'd0, m_data};
      2'd1:    return {15'd0, m_lzs, 2'b00, m_blink, 2'b00, m_blank};
      2'd2:    return m_half;
      default: return {31'd0, m_phase()};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data  <= '0;
      m_blank <= '0;
      m_blink <= '0;
      m_lzs   <= 1'b0;
      m_half  <= 32'd25000000;
      m_ticks <= 0;
      m_out   <= ALL_ZERO_OUT;
    end else begin
      m_out <= expect_out(m_data, m_blank, m_blink, m_lzs, m_phase());
      if (chipselect && !write_n && address == 2'd2) m_ticks <= 0;
      else if (m_half != 32'd0) m_ticks <= m_ticks + 1;
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_data <= writedata[23:0];
          2'd1: begin
            m_blank <= writedata[5:0];
            m_blink <= writedata[13:8];
            m_lzs   <= writedata[16];
          end
          2'd2: m_half <= writedata;
          default: ;
        endcase
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd = '{32'd0, 32'd0, 32'd25000000, 32'd0};
    n_checks++;
    if (out_port !== ALL_ZERO_OUT) $display("FAIL reset_out: got %h want %h", out_port, ALL_ZERO_OUT);
    else n_pass++;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      n_checks++;
      if (readdata !== exp_rd[a]) $display("FAIL reset_read%0d: got %h want %h", a, readdata, exp_rd[a]);
      else n_pass++;
    end
  endtask

  task automatic test_data();
    logic [41:0] exp;
    exp = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    bus_write(2'd0, 32'h00123456);
    address = 2'd0;
    #1;
    n_checks++;
    if (readdata !== 32'h00123456) $display("FAIL data_readback: got %h want %h", readdata, 32'h00123456);
    else n_pass++;
    n_checks++;
    if (out_port !== ALL_ZERO_OUT) $display("FAIL data_latency: got %h want %h", out_port, ALL_ZERO_OUT);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_port !== exp) $display("FAIL data_decode: got %h want %h", out_port, exp);
    else n_pass++;
  endtask

  task automatic test_lzs();
    logic [41:0] exp;
    bus_write(2'd0, 32'h00000040);
    bus_write(2'd1, 32'h00010000);
    @(negedge clk);
    exp = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h40};
    n_checks++;
    if (out_port !== exp) $display("FAIL lzs_40: got %h want %h", out_port, exp);
    else n_pass++;
    address = 2'd1;
    #1;
    n_checks++;
    if (readdata !== 32'h00010000) $display("FAIL lzs_ctrl_read: got %h want %h", readdata, 32'h00010000);
    else n_pass++;
    bus_write(2'd0, 32'h0);
    @(negedge clk);
    exp = {{5{7'h7F}}, 7'h40};
    n_checks++;
    if (out_port !== exp) $display("FAIL lzs_zero: got %h want %h", out_port, exp);
    else n_pass++;
  endtask

  task automatic test_blink();
    logic prev_phase;
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'h00123456);
    bus_write(2'd2, 32'd4);
    bus_write(2'd1, 32'h00000100);
    @(negedge clk);
    address = 2'd3;
    #1;
    prev_phase = readdata[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      address = 2'd3;
      #1;
      n_checks++;
      if (readdata[0] !== m_phase()) $display("FAIL blink_phase c%0d: got %b want %b", c, readdata[0], m_phase());
      else n_pass++;
      n_checks++;
      if (out_port[6:0] !== (prev_phase ? 7'h7F : 7'h02))
        $display("FAIL blink_digit0 c%0d: got %h want %h", c, out_port[6:0], prev_phase ? 7'h7F : 7'h02);
      else n_pass++;
      n_checks++;
      if (out_port[41:7] !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12})
        $display("FAIL blink_others c%0d: got %h", c, out_port[41:7]);
      else n_pass++;
      prev_phase = readdata[0];
    end
  endtask

  task automatic test_rewrite_half();
    int guard;
    guard = 0;
    while (m_ticks % 4 != 3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 20) $display("FAIL rewrite_wait: timebase never reached cnt=3 (%0d cycles)", guard);
    else n_pass++;
    bus_write(2'd2, 32'd4);
    for (int j = 0; j < 5; j++) begin
      address = 2'd3;
      #1;
      n_checks++;
      if (readdata[0] !== (j == 4)) $display("FAIL rewrite_phase j%0d: got %b want %b", j, readdata[0], (j == 4));
      else n_pass++;
      @(negedge clk);
    end
    bus_write(2'd1, 32'h00000101);
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (out_port[6:0] !== 7'h7F) $display("FAIL blank_over_blink c%0d: got %h want 7f", c, out_port[6:0]);
      else n_pass++;
      n_checks++;
      if (out_port !== m_out) $display("FAIL blank_blink_model c%0d: got %h want %h", c, out_port, m_out);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bus_write(2'd0, 32'h00ABCDEF);
    bus_write(2'd2, 32'd3);
    bus_write(2'd1, 32'h00003F00);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    address = 2'd3;
    #1;
    n_checks++;
    if (out_port !== ALL_ZERO_OUT) $display("FAIL async_reset_out: got %h want %h", out_port, ALL_ZERO_OUT);
    else n_pass++;
    n_checks++;
    if (readdata !== 32'd0) $display("FAIL async_reset_status: got %h want 0", readdata);
    else n_pass++;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(negedge clk);
    address = 2'd1;
    #1;
    n_checks++;
    if (readdata !== 32'd0) $display("FAIL async_reset_ctrl: got %h want 0", readdata);
    else n_pass++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_port !== ALL_ZERO_OUT) $display("FAIL post_reset_out c%0d: got %h want %h", c, out_port, ALL_ZERO_OUT);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bus_write(2'd0, 32'h00FEDCBA);
    bus_write(2'd1, 32'h00000003);
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h00000C0D);
    address = 2'd0;
    #1;
    n_checks++;
    if (readdata !== 32'h00000C0D) $display("FAIL b2b_data: got %h want %h", readdata, 32'h00000C0D);
    else n_pass++;
    address = 2'd1;
    #1;
    n_checks++;
    if (readdata !== 32'h00000003) $display("FAIL b2b_ctrl: got %h want %h", readdata, 32'h00000003);
    else n_pass++;
    address = 2'd2;
    #1;
    n_checks++;
    if (readdata !== 32'd2) $display("FAIL b2b_half: got %h want %h", readdata, 32'd2);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_port !== {7'h40, 7'h40, 7'h40, 7'h46, 7'h7F, 7'h7F})
      $display("FAIL b2b_out: got %h want %h", out_port, {7'h40, 7'h40, 7'h40, 7'h46, 7'h7F, 7'h7F});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0]  a;
    logic [31:0] d;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
      end else begin
        a = 2'($urandom_range(0, 3));
        case (a)
          2'd0:    d = $urandom >> (4 * $urandom_range(0, 6));
          2'd2:    d = $urandom_range(0, 6);
          default: d = $urandom;
        endcase
        bus_write(a, d);
      end
      n_checks++;
      if (out_port !== m_out) $display("FAIL rand_out it%0d: got %h want %h", it, out_port, m_out);
      else n_pass++;
      address = 2'($urandom_range(0, 3));
      #1;
      n_checks++;
      if (readdata !== m_read(address))
        $display("FAIL rand_read it%0d a%0d: got %h want %h", it, address, readdata, m_read(address));
      else n_pass++;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_data();
    test_lzs();
    test_blink();
    test_rewrite_half();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
